fifo_stream_reader: RTL and testbench
=====================================

Name: fifo_stream_reader

Overview:
- Consumer-side companion to the team's synchronous FIFO.
- Pops words through the FIFO's registered read port (read_en in, data_out valid one cycle later, empty flag) and presents them on a valid/ready stream.
- Holds a small skid buffer that hides the one-cycle read latency, so the stream sustains one word per cycle with no bubbles.
- Sits between any FIFO instance and a downstream stream sink (serializer, packet builder).

Parameters:
- DATA_WIDTH, 8, width of FIFO words and stream data.
- BUF_DEPTH, 2, skid buffer entries; minimum 2 (required for full throughput); any value of 2 or more, not limited to powers of two.
- CNT_WIDTH, 16, width of the delivered-word counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- fifo_empty  in  1  FIFO empty flag.
- fifo_data  in  DATA_WIDTH  FIFO data_out; valid the cycle after an accepted read.
- fifo_rd_en  out  1  FIFO read_en.
- flush  in  1  synchronous discard of buffered and in-flight words.
- m_valid  out  1  stream word valid.
- m_data  out  DATA_WIDTH  stream word.
- m_ready  in  1  sink accepts the word when m_valid && m_ready.
- words_out  out  CNT_WIDTH  count of words accepted by the sink.

Behaviour:
- Reset (async, rst=1):
  - occ=0, inflight=0, rd/wr pointers=0, words_out=0.
  - m_valid=0, m_data=0, fifo_rd_en=0.
- State:
  - occ = buffered entries, 0..BUF_DEPTH.
  - inflight = 1-bit flag, set the cycle after fifo_rd_en=1.
  - Circular buffer with wrapping head/tail pointers; wrap at BUF_DEPTH-1 back to 0 for any BUF_DEPTH value.
- pop = m_valid && m_ready.
- fifo_rd_en = !fifo_empty && !flush && !rst && (occ + inflight - pop) < BUF_DEPTH.
  - Combinational.
  - The m_ready to fifo_rd_en path is intentional.
  - Never asserted when fifo_empty=1, so every asserted read is accepted by the FIFO.
- Capture: if inflight=1 and no flush this cycle, fifo_data is written at the tail on the clock edge.
- m_valid = (occ != 0); m_data = buffer[head]. Both derive from registered state and carry no combinational path from inputs.
- Simultaneous capture and pop: occ unchanged; head and tail both advance.
- Overflow cannot occur by construction; the bench asserts occ <= BUF_DEPTH.
- Latency: FIFO non-empty to m_valid is 2 cycles (rd_en cycle, capture cycle, then valid).
- Steady state: sink always ready and FIFO non-empty gives 1 word/cycle.
- Backpressure: m_ready=0 with m_valid=1 holds m_data stable. Reads stop once occ+inflight reaches BUF_DEPTH.
- Flush:
  - In the flush cycle: occ becomes 0, pointers reset, fifo_rd_en=0, pop is ignored, words_out is not incremented.
  - A word in flight during the flush cycle is discarded on arrival, because inflight is cleared and capture is suppressed.
  - m_valid=0 the cycle after flush.
  - Reading resumes the cycle after flush deasserts.
- words_out: increments on each pop and wraps modulo 2^CNT_WIDTH.
- Reset mid-operation: immediate clear. Any FIFO read issued in the reset cycle is impossible because fifo_rd_en is gated by rst.

Decomposition:
- Shared package (fifo_pkg): DATA_WIDTH default, minimum BUF_DEPTH constant, and the occupancy width function clog2(BUF_DEPTH+1).
- One natural sub-module: stream_skid_buf, the circular buffer with occupancy, head/tail, push/pop/clear.
- fifo_stream_reader keeps the read-issue logic, the inflight flag, flush handling and the counter.

Test Plan:
- Reset: FIFO holds 0x11,0x22,0x33; release rst with m_ready=1 -> fifo_rd_en high in the first cycle; m_valid rises 2 cycles later; stream emits 0x11,0x22,0x33 on consecutive cycles; words_out=3.
- Throughput: 8 words 0x00..0x07 preloaded, m_ready=1 -> 8 consecutive valid cycles with no bubble; fifo_rd_en high for 8 consecutive cycles.
- Backpressure: 4 words queued; m_ready=0 for 5 cycles after the first valid -> m_data stays 0x00 while m_valid=1; exactly 2 reads issued; release m_ready -> 0x00..0x03 in order.
- Empty boundary: a single word 0xA5 then FIFO empty, m_ready=1 -> one read only; one valid beat of 0xA5; m_valid=0 afterwards; fifo_rd_en never high while fifo_empty=1.
- Flush: flush pulse while occ=1 and a word (0x42) is in flight -> m_valid=0 the next cycle; 0x42 never appears on m_data; words_out unchanged; reading resumes and the next FIFO word is output.
- Async reset mid-stream: rst asserted between clock edges with occ=2 -> m_valid, fifo_rd_en and words_out all read 0 immediately, before the next edge.

Source files
------------

// File: rtl/fifo_stream_reader_pkg.sv
// fifo_stream_reader_pkg: shared constants and sizing helpers for the FIFO
// stream reader and its skid buffer.
// No ports; imported by the interface, the skid buffer and the top.
package fifo_stream_reader_pkg;

  // Default word width, shared by the FIFO data port and the output stream.
  localparam int DEF_DATA_WIDTH = 8;

  // Two entries are the least that cover the one-cycle FIFO read latency
  // while a word is also being popped, so the stream never bubbles.
  localparam int MIN_BUF_DEPTH = 2;

  // Default width of the delivered-word counter.
  localparam int DEF_CNT_WIDTH = 16;

  // Occupancy must be able to hold the value DEPTH itself, not only DEPTH-1.
  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Pointer width for a circular buffer of DEPTH entries. Never narrower
  // than one bit, so that a degenerate depth still elaborates.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// fifo_stream_reader_if: bundles the FIFO read port and the output stream.
// FIFO side: fifo_empty, fifo_data (in to reader), fifo_rd_en (out of reader).
// Stream side: m_valid, m_data (out of reader), m_ready (in to reader).
// The master modport is the reader; the slave modport is its environment.
interface fifo_stream_reader_if
  import fifo_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

  // FIFO registered read port
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  fifo_rd_en;

  // Valid/ready output stream
  logic                  m_valid;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_ready;

  modport master (
    input  fifo_empty,
    input  fifo_data,
    input  m_ready,
    output fifo_rd_en,
    output m_valid,
    output m_data
  );

  modport slave (
    output fifo_empty,
    output fifo_data,
    output m_ready,
    input  fifo_rd_en,
    input  m_valid,
    input  m_data
  );

endinterface

// File: rtl/fifo_stream_reader_skid_buf.sv
// stream_skid_buf: circular buffer of DEPTH words with occupancy count.
// Ports: clk, rst (async, active high), clear (synchronous empty), push +
// push_data (write at tail), pop (advance head), occ, head_data (word at head).
// Latency: a pushed word is visible at head_data the cycle after the push.
module stream_skid_buf
  import fifo_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = MIN_BUF_DEPTH,
  localparam int OCC_W     = occ_width(DEPTH),
  localparam int PTR_W     = ptr_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [OCC_W-1:0]      occ,
  output logic [DATA_WIDTH-1:0] head_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;

  // Explicit wrap compare so that non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  // Storage is reset too so that the stream data reads zero out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push && !clear) begin
      mem[tail] <= push_data;
    end
  end

  // Clear wins over push and pop: everything buffered or arriving is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else if (clear) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else begin
      if (push) begin
        tail <= wrap_inc(tail);
      end
      if (pop) begin
        head <= wrap_inc(head);
      end
      // Simultaneous push and pop leave the occupancy unchanged.
      case ({push, pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  assign head_data = mem[head];

endmodule

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: pops a synchronous FIFO and presents its words on a
// valid/ready stream at one word per cycle, hiding the FIFO's read latency.
// Latency: FIFO non-empty to m_valid is 2 cycles (read cycle, capture cycle).
// Backpressure: m_ready=0 holds m_data; reads stop once buffered + in-flight
// words fill the skid buffer.
// Ports: clk, rst (async, active high), flush (synchronous discard),
// bus (FIFO read port + output stream, master side), words_out (beat count).
module fifo_stream_reader
  import fifo_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BUF_DEPTH  = MIN_BUF_DEPTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  fifo_stream_reader_if.master     bus,
  output logic [CNT_WIDTH-1:0]     words_out
);

  localparam int OCC_W = occ_width(BUF_DEPTH);
  // One extra bit so occ + inflight never overflows before the compare.
  localparam logic [OCC_W:0] DEPTH_LIMIT = (OCC_W + 1)'(BUF_DEPTH);

  logic [OCC_W-1:0]      occ;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  inflight;
  logic                  pop;
  logic                  beat;
  logic                  capture;
  logic                  rd_en;
  logic [OCC_W:0]        pending;

  // A handshake on the stream; ignored entirely in a flush cycle.
  assign pop  = bus.m_valid && bus.m_ready;
  assign beat = pop && !flush;

  // Entries that will be occupied after this edge if no new read is issued.
  // pop implies occ >= 1, so the subtraction cannot underflow.
  assign pending = {1'b0, occ}
                 + (OCC_W + 1)'(inflight)
                 - (OCC_W + 1)'(pop);

  // Counting the same-cycle pop lets the reader keep one read in flight
  // every cycle at depth 2; this is why m_ready reaches fifo_rd_en
  // combinationally. Gating with rst keeps a reset cycle from consuming a
  // FIFO word that would then be lost.
  assign rd_en = !bus.fifo_empty && !flush && !rst && (pending < DEPTH_LIMIT);
  assign bus.fifo_rd_en = rd_en;

  // The FIFO word appears the cycle after the read; a flush in that cycle
  // drops it on arrival.
  assign capture = inflight && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= 1'b0;
    end else begin
      // rd_en is already forced low during flush, which clears the flag.
      inflight <= rd_en;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      words_out <= '0;
    end else if (beat) begin
      words_out <= words_out + CNT_WIDTH'(1);
    end
  end

  stream_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (BUF_DEPTH)
  ) u_skid_buf (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush),
    .push      (capture),
    .push_data (bus.fifo_data),
    .pop       (beat),
    .occ       (occ),
    .head_data (head_data)
  );

  // Both stream outputs come straight from registers.
  assign bus.m_valid = (occ != '0);
  assign bus.m_data  = head_data;

endmodule

// File: tb/tb_fifo_stream_reader.sv
module tb_fifo_stream_reader;

  localparam int DW = 8;
  localparam int BD = 2;
  localparam int CW = 16;

  logic          clk   = 1'b0;
  logic          rst   = 1'b1;
  logic          flush = 1'b0;
  logic [CW-1:0] words_out;

  fifo_stream_reader_if #(.DATA_WIDTH(DW)) bus ();

  fifo_stream_reader #(
    .DATA_WIDTH (DW),
    .BUF_DEPTH  (BD),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .bus       (bus),
    .words_out (words_out)
  );

  always #5 clk = ~clk;

  // Synchronous FIFO model: registered data_out, empty flag from pointers.
  logic [DW-1:0] fmem [4096];
  int            wr_ptr = 0;
  int            rd_ptr = 0;

  assign bus.fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (bus.fifo_rd_en) begin
      bus.fifo_data <= fmem[rd_ptr];
      rd_ptr        <= rd_ptr + 1;
    end
  end

  // Reference: the stream carries FIFO words in order; words read from the
  // FIFO but not yet delivered are lost on flush or reset.
  int            next_idx  = 0;
  logic [CW-1:0] exp_words = '0;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  logic          o_vld;
  logic          o_rd;
  logic [DW-1:0] o_dat;
  logic [DW-1:0] last_beat;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [DW-1:0] b);
    fmem[wr_ptr] = b;
    wr_ptr++;
  endtask

  // One clock cycle: starts and ends at a falling edge.
  task automatic cyc(input logic rdy, input logic fl);
    bus.m_ready = rdy;
    flush       = fl;
    #1;
    o_vld = bus.m_valid;
    o_rd  = bus.fifo_rd_en;
    o_dat = bus.m_data;
    if (bus.fifo_empty) check("rd_while_empty", {31'd0, o_rd}, 32'd0);
    if (o_vld && rdy && !fl) begin
      check("stream_data", {24'd0, o_dat}, {24'd0, fmem[next_idx]});
      last_beat = o_dat;
      next_idx++;
      exp_words++;
    end
    @(posedge clk);
    if (fl) next_idx = rd_ptr;
    @(negedge clk);
    flush = 1'b0;
    check("words_out", {16'd0, words_out}, {16'd0, exp_words});
    check("occ_bound", {31'd0, ((rd_ptr - next_idx) <= BD)}, 32'd1);
  endtask

  initial begin
    logic [11:0] vv;
    logic [11:0] rv;
    int          cr;
    int          cv;
    int          wsave;
    bit          r;
    bit          f;

    bus.m_ready = 1'b0;
    bus.fifo_data = '0;

    // Reset state with FIFO already holding words.
    push(8'h11); push(8'h22); push(8'h33);
    @(negedge clk);
    check("rst_m_valid", {31'd0, bus.m_valid}, 32'd0);
    check("rst_m_data", {24'd0, bus.m_data}, 32'd0);
    check("rst_rd_en", {31'd0, bus.fifo_rd_en}, 32'd0);
    check("rst_words_out", {16'd0, words_out}, 32'd0);
    rst = 1'b0;

    // Latency after reset release.
    vv = '0; rv = '0;
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 1'b0);
      vv[i] = o_vld; rv[i] = o_rd;
    end
    check("t1_valid_pattern", {26'd0, vv[5:0]}, 32'b011100);
    check("t1_rd_pattern", {26'd0, rv[5:0]}, 32'b000111);
    check("t1_words_out", {16'd0, words_out}, 32'd3);

    // Throughput: 8 words, no bubbles.
    for (int i = 0; i < 8; i++) push(DW'(i));
    vv = '0; rv = '0;
    for (int i = 0; i < 12; i++) begin
      cyc(1'b1, 1'b0);
      vv[i] = o_vld; rv[i] = o_rd;
    end
    check("t2_valid_pattern", {20'd0, vv}, 32'h3FC);
    check("t2_rd_pattern", {20'd0, rv}, 32'h0FF);
    check("t2_words_out", {16'd0, words_out}, 32'd11);

    // Backpressure: data held, exactly two reads.
    for (int i = 0; i < 4; i++) push(DW'(i));
    cr = 0;
    for (int i = 0; i < 7; i++) begin
      cyc(1'b0, 1'b0);
      cr += int'(o_rd);
      if (i >= 2) begin
        check("t3_hold_valid", {31'd0, o_vld}, 32'd1);
        check("t3_hold_data", {24'd0, o_dat}, 32'd0);
      end
    end
    check("t3_read_count", cr, 32'd2);
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0);
    check("t3_words_out", {16'd0, words_out}, 32'd15);

    // Empty boundary: single word.
    push(8'hA5);
    cr = 0; cv = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 1'b0);
      cr += int'(o_rd);
      cv += int'(o_vld);
    end
    check("t4_read_count", cr, 32'd1);
    check("t4_valid_count", cv, 32'd1);
    check("t4_last_beat", {24'd0, last_beat}, 32'hA5);
    check("t4_valid_after", {31'd0, o_vld}, 32'd0);

    // Flush with one buffered word and 0x42 in flight.
    push(8'h40); push(8'h42); push(8'h43);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    wsave = int'(words_out);
    cyc(1'b1, 1'b1);
    check("t5_words_unchanged", {16'd0, words_out}, wsave);
    cyc(1'b1, 1'b0);
    check("t5_valid_after_flush", {31'd0, o_vld}, 32'd0);
    check("t5_read_resumes", {31'd0, o_rd}, 32'd1);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0);
    check("t5_next_word", {24'd0, last_beat}, 32'h43);
    check("t5_words_out", {16'd0, words_out}, wsave + 1);

    // Randomized traffic, backpressure and flushes.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) != 0) push(DW'($urandom));
      r = ($urandom_range(0, 3) != 0);
      f = ($urandom_range(0, 24) == 0);
      cyc(r, f);
    end
    for (int i = 0; i < 1000 && next_idx != wr_ptr; i++) cyc(1'b1, 1'b0);
    check("rand_drain_complete", next_idx, wr_ptr);
    check("rand_idle_valid", {31'd0, bus.m_valid}, 32'd0);

    // Async reset mid-stream with two words buffered.
    push(8'h71); push(8'h72); push(8'h73);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0);
    bus.m_ready = 1'b1;
    #1;
    check("t7_pre_valid", {31'd0, bus.m_valid}, 32'd1);
    check("t7_pre_rd_en", {31'd0, bus.fifo_rd_en}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("t7_async_valid", {31'd0, bus.m_valid}, 32'd0);
    check("t7_async_rd_en", {31'd0, bus.fifo_rd_en}, 32'd0);
    check("t7_async_words", {16'd0, words_out}, 32'd0);
    check("t7_async_data", {24'd0, bus.m_data}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    next_idx  = rd_ptr;
    exp_words = '0;
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0);
    check("t7_after_words", {16'd0, words_out}, 32'd1);
    check("t7_after_data", {24'd0, last_beat}, 32'h73);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
